// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//
// Shares one external single-cycle combinational ALU between two requesters
// (R0, R1). A granted request has its operands and operation registered into
// the ALU inputs. The result and zero flag are captured one cycle later and
// returned on a tagged valid/ready response channel.
//
// Operation sequence: IDLE (grant) -> EXEC (ALU settles) -> RESP (hold until
// accepted). With rsp_ready tied high this gives one operation every 3 cycles.
//
// Build option:
//   ALU_SHARE_FIXED_PRIO_EN  defined   : R0 always wins a tie; R1 can starve.
//                            undefined : round-robin on ties (default).
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   req0_* / req1_*       request channels (valid, ready, op, a, b)
//   alu_inA/alu_inB/alu_op  registered operands/op driven to the ALU
//   alu_result/alu_zero   ALU outputs, sampled at the end of EXEC
//   rsp_valid/rsp_ready   response handshake
//   rsp_id                index of the requester being answered
//   rsp_result/rsp_zero   captured ALU result and zero flag
//   busy                  high while in EXEC or RESP
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter int W   = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,

    output logic [W-1:0]   alu_inA,
    output logic [W-1:0]   alu_inB,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_zero,

    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_result,
    output logic           rsp_zero,

    output logic           busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic grant0;
    logic grant1;
    logic grant_any;

`ifndef ALU_SHARE_FIXED_PRIO_EN
    // Index of the last requester served; a tie goes to the other one.
    logic rr_last;
`endif

    // ------------------------------------------------------------------
    // Arbitration (combinational; only meaningful while IDLE)
    // ------------------------------------------------------------------
    always_comb begin
        grant1 = 1'b0;
`ifdef ALU_SHARE_FIXED_PRIO_EN
        grant1 = req1_valid & ~req0_valid;
`else
        // R1 wins when alone, or on a tie when R0 was served last.
        grant1 = req1_valid & (~req0_valid | ~rr_last);
`endif
        grant0    = req0_valid & ~grant1;
        grant_any = grant0 | grant1;
    end

    assign req0_ready = (state == S_IDLE) & grant0;
    assign req1_ready = (state == S_IDLE) & grant1;
    assign busy       = (state == S_EXEC) | (state == S_RESP);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_any) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // alu_* hold their value outside the grant edge, so the ALU output is
    // simply ignored except at the end of EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_inA    <= '0;
            alu_inB    <= '0;
            alu_op     <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_valid  <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            rr_last    <= 1'b1;   // R0 wins the first tie
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        alu_op  <= grant1 ? req1_op : req0_op;
                        alu_inA <= grant1 ? req1_a  : req0_a;
                        alu_inB <= grant1 ? req1_b  : req0_b;
                        rsp_id  <= grant1;
`ifndef ALU_SHARE_FIXED_PRIO_EN
                        rr_last <= grant1;
`endif
                    end
                end
                S_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_valid  <= 1'b1;
                end
                S_RESP: begin
                    // rsp_* stay frozen until the consumer takes them.
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
